reg_enable_decoder: RTL and testbench

//  Parametrised register-enable decoder for the processor datapath. Latches a

---
 rtl/reg_enable_decoder.sv | 143 ++++++++++++++
 tb/tb_reg_enable_decoder.sv | 125 ++++++++++++
 2 files changed

// File: rtl/reg_enable_decoder.sv
// Register-enable decoder: latches a select code, decodes it to a one-hot
// enable vector, and drives the enables either as a level or as a fixed-length burst.
module reg_enable_decoder #(
  parameter int                 SEL_W      = 4,
  parameter int                 NUM_OUT    = 12,
  parameter int                 SEL_OFFSET = 1,
  parameter logic [NUM_OUT-1:0] VALID_MASK = 12'hFF9,
  parameter int                 MODE       = 0,
  parameter int                 PULSE_LEN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  input  logic               en_op,
  input  logic               en_out,
  output logic [NUM_OUT-1:0] en,
  output logic               sel_err,
  output logic               busy
);

  localparam int                 CNT_W  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [SEL_W:0]     OFF_W  = (SEL_W+1)'(SEL_OFFSET);
  localparam logic [NUM_OUT-1:0] ONE_OH = NUM_OUT'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_OUT-1:0] en_q, en_d;
  logic [NUM_OUT-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   eff_s;
  logic [NUM_OUT-1:0] onehot_s;
  logic               hit_s;

  // Index is formed one bit wider than the code so codes below the offset
  // can never alias onto a low output.
  function automatic logic [NUM_OUT-1:0] decode(input logic [SEL_W-1:0] code);
    logic [SEL_W:0]     idx;
    logic [NUM_OUT-1:0] oh;
    idx = {1'b0, code} - OFF_W;
    if (({1'b0, code} >= OFF_W) && (32'(idx) < 32'(NUM_OUT))) begin
      oh = (ONE_OH << idx) & VALID_MASK;
    end else begin
      oh = '0;
    end
    return oh;
  endfunction

  assign eff_s    = en_op ? sel : sel_q;
  assign onehot_s = decode(eff_s);
  assign hit_s    = |onehot_s;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    en_d    = '0;
    if (en_op) begin
      sel_d = sel;
      err_d = ~hit_s;
    end else begin
      sel_d = sel_q;
    end
    if (MODE == 0) begin
      en_d    = en_out ? onehot_s : '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_out && hit_s) begin
            en_d  = onehot_s;
            tgt_d = onehot_s;
            if (PULSE_LEN > 1) begin
              cnt_d   = CNT_W'(PULSE_LEN - 2);
              state_d = PULSE;
            end else begin
              state_d = WAIT_LOW;
            end
          end else if (en_out) begin
            state_d = WAIT_LOW;
          end else begin
            state_d = IDLE;
          end
        end
        // cnt==0 marks the final burst cycle, giving PULSE_LEN cycles in total.
        PULSE: begin
          if (!en_out) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            en_d    = tgt_q;
            state_d = WAIT_LOW;
          end else begin
            en_d  = tgt_q;
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (!en_out) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_LOW;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign en      = en_q;
  assign sel_err = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reg_enable_decoder.sv
// Scoreboard bench: one level-mode and two pulse-mode instances share the
// stimulus; each directed sequence checks only the instance it targets.
module tb_reg_enable_decoder;

  logic        clk = 1'b0;
  logic        rst, en_op, en_out;
  logic [3:0]  sel;
  logic [11:0] en_l, en_p3, en_p4;
  logic        err_l, err_p3, err_p4;
  logic        busy_l, busy_p3, busy_p4;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          dut;
    logic [11:0] en;
    logic        err;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  reg_enable_decoder #(.MODE(0), .PULSE_LEN(1)) u_lvl (
    .clk(clk), .rst(rst), .sel(sel), .en_op(en_op), .en_out(en_out),
    .en(en_l), .sel_err(err_l), .busy(busy_l)
  );

  reg_enable_decoder #(.MODE(1), .PULSE_LEN(3)) u_p3 (
    .clk(clk), .rst(rst), .sel(sel), .en_op(en_op), .en_out(en_out),
    .en(en_p3), .sel_err(err_p3), .busy(busy_p3)
  );

  reg_enable_decoder #(.MODE(1), .PULSE_LEN(4)) u_p4 (
    .clk(clk), .rst(rst), .sel(sel), .en_op(en_op), .en_out(en_out),
    .en(en_p4), .sel_err(err_p4), .busy(busy_p4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then score after the edge.
  task automatic apply(input int d, input logic r, input logic op, input logic [3:0] s,
                       input logic eo, input logic [11:0] xen, input logic xerr,
                       input logic xbusy);
    exp_t        e;
    logic [11:0] g_en;
    logic        g_err, g_busy;
    @(negedge clk);
    rst    = r;
    en_op  = op;
    sel    = s;
    en_out = eo;
    exp_q.push_back('{d, xen, xerr, xbusy});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    case (e.dut)
      0:       begin g_en = en_l;  g_err = err_l;  g_busy = busy_l;  end
      1:       begin g_en = en_p3; g_err = err_p3; g_busy = busy_p3; end
      default: begin g_en = en_p4; g_err = err_p4; g_busy = busy_p4; end
    endcase
    check_val($sformatf("v%0d_d%0d_en", vectors / 3, e.dut), 32'(g_en), 32'(e.en));
    check_val($sformatf("v%0d_d%0d_err", vectors / 3, e.dut), 32'(g_err), 32'(e.err));
    check_val($sformatf("v%0d_d%0d_busy", vectors / 3, e.dut), 32'(g_busy), 32'(e.busy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en_op = 1'b0; en_out = 1'b0; sel = 4'h0;

    // Level mode
    apply(0, 1'b1, 1'b0, 4'h0, 1'b0, 12'h000, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b1, 4'h5, 1'b1, 12'h010, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b0, 4'h9, 1'b1, 12'h010, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b0, 4'h9, 1'b0, 12'h000, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b1, 4'h2, 1'b1, 12'h000, 1'b1, 1'b0);
    apply(0, 1'b0, 1'b1, 4'hD, 1'b1, 12'h000, 1'b1, 1'b0);
    apply(0, 1'b0, 1'b1, 4'h0, 1'b1, 12'h000, 1'b1, 1'b0);
    apply(0, 1'b0, 1'b1, 4'hC, 1'b1, 12'h800, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b1, 4'h1, 1'b1, 12'h001, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b1, 4'h4, 1'b1, 12'h008, 1'b0, 1'b0);
    apply(0, 1'b0, 1'b1, 4'hF, 1'b0, 12'h000, 1'b1, 1'b0);
    apply(0, 1'b0, 1'b0, 4'h5, 1'b1, 12'h000, 1'b1, 1'b0);

    // Pulse mode, 3-cycle bursts
    apply(1, 1'b1, 1'b0, 4'h0, 1'b0, 12'h000, 1'b0, 1'b0);
    apply(1, 1'b0, 1'b1, 4'hC, 1'b0, 12'h000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      apply(1, 1'b0, 1'b0, 4'h0, 1'b1, (i < 3) ? 12'h800 : 12'h000, 1'b0, 1'b1);
    apply(1, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      apply(1, 1'b0, 1'b0, 4'h0, 1'b1, (i < 3) ? 12'h800 : 12'h000, 1'b0, 1'b1);
    apply(1, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 1'b0, 1'b0);
    apply(1, 1'b0, 1'b1, 4'h2, 1'b1, 12'h000, 1'b1, 1'b1);
    apply(1, 1'b0, 1'b0, 4'h2, 1'b0, 12'h000, 1'b1, 1'b0);

    // Pulse mode, 4-cycle bursts: retarget mid-burst, abort, reset mid-burst
    apply(2, 1'b1, 1'b0, 4'h0, 1'b0, 12'h000, 1'b0, 1'b0);
    apply(2, 1'b0, 1'b1, 4'h4, 1'b1, 12'h008, 1'b0, 1'b1);
    apply(2, 1'b0, 1'b1, 4'h2, 1'b1, 12'h008, 1'b1, 1'b1);
    apply(2, 1'b0, 1'b0, 4'h2, 1'b0, 12'h000, 1'b1, 1'b0);
    apply(2, 1'b0, 1'b1, 4'hC, 1'b1, 12'h800, 1'b0, 1'b1);
    apply(2, 1'b0, 1'b1, 4'hF, 1'b1, 12'h800, 1'b1, 1'b1);
    apply(2, 1'b1, 1'b0, 4'hC, 1'b1, 12'h000, 1'b0, 1'b0);
    apply(2, 1'b0, 1'b0, 4'hC, 1'b1, 12'h000, 1'b0, 1'b1);
    apply(2, 1'b0, 1'b0, 4'hC, 1'b0, 12'h000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
